// File: rtl/uart_tx_fifo_cfg_pkg.sv
// Shared definitions for the configurable UART transmitter.
//
// Contents:
//   - FSM state encodings used by uart_tx_fifo_cfg
//   - standard bit-period divisors for a 12 MHz system clock
//   - the legal range of the DATA_BITS parameter
//
// No ports; imported with "import uart_tx_fifo_cfg_pkg::*;".
package uart_tx_fifo_cfg_pkg;

    // Transmit FSM states. Kept as plain constants so older code that
    // compares against raw encodings keeps working.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;
    localparam logic [2:0] ST_STOP   = 3'd5;

    // Clocks per bit for common baud rates at 12 MHz.
    localparam int B9600   = 1250;
    localparam int B19200  = 625;
    localparam int B38400  = 313;
    localparam int B57600  = 208;
    localparam int B115200 = 104;

    // Legal number of data bits per frame.
    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;

endpackage

// File: rtl/uart_tx_fifo_cfg_sync_fifo.sv
// Synchronous FIFO in front of the UART transmitter.
//
// Ports:
//   clk      in   system clock
//   rstn     in   asynchronous active-low reset; empties the FIFO
//   push_i   in   write data_i (ignored while ready_o is low)
//   data_i   in   WIDTH-bit word to store
//   pop_i    in   drop the head entry (ignored while empty_o is high)
//   data_o   out  head entry (valid while empty_o is low)
//   ready_o  out  registered "not full", low during reset
//   empty_o  out  registered empty flag
//   level_o  out  registered number of stored words
module uart_tx_fifo_cfg_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     ready_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      level_q;
    logic [AW:0]      level_d;
    logic             ready_q;
    logic             empty_q;
    logic             doPush;
    logic             doPop;

    assign doPush = push_i && ready_q;
    assign doPop  = pop_i && !empty_q;

    // A simultaneous push and pop leaves the level unchanged.
    always_comb begin
        level_d = level_q;
        if (doPush && !doPop) begin
            level_d = level_q + 1'b1;
        end else if (!doPush && doPop) begin
            level_d = level_q - 1'b1;
        end
    end

    // Flags are derived from the next level so they are plain flops;
    // ready stays low while in reset. Pointers wrap naturally because
    // DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
            ready_q <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
            level_q <= level_d;
            ready_q <= (level_d != FULL_LEVEL);
            empty_q <= (level_d == '0);
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q] <= data_i;
    end

    assign data_o  = mem_q[rdPtr_q];
    assign ready_o = ready_q;
    assign empty_o = empty_q;
    assign level_o = level_q;

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// Configurable UART transmitter with input FIFO.
// Frame: start(0), DATA_BITS data LSB first, optional parity, STOP_BITS ones;
// every bit lasts BAUD_DIV clocks. Back-to-back frames are separated by one
// idle-high clock (the LOAD cycle).
//
// Optional feature: define UART_TX_PARITY_EN to add parity_en/parity_odd
// and a parity bit after the data bits.
//
// Ports:
//   clk         in   system clock
//   rstn        in   asynchronous active-low reset; flushes FIFO, aborts frame
//   parity_en   in   (UART_TX_PARITY_EN only) send a parity bit this frame
//   parity_odd  in   (UART_TX_PARITY_EN only) odd instead of even parity
//   in_valid    in   in_data valid
//   in_data     in   word to send
//   in_ready    out  FIFO can accept a word
//   tx          out  registered serial line, idle high
//   busy        out  frame in flight or FIFO not empty
//   fifo_level  out  words queued, excluding the one being sent
module uart_tx_fifo_cfg
    import uart_tx_fifo_cfg_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int BAUD_DIV   = 1250,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
`ifdef UART_TX_PARITY_EN
    input  logic                          parity_en,
    input  logic                          parity_odd,
`endif
    input  logic                          in_valid,
    input  logic [DATA_BITS-1:0]          in_data,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    logic [2:0]           state_q, state_d;
    logic [BW-1:0]        baudCnt_q, baudCnt_d;
    logic [3:0]           bitCnt_q, bitCnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 busy_q;
`ifdef UART_TX_PARITY_EN
    logic                 parEn_q, parEn_d;
    logic                 parBit_q, parBit_d;
`endif

    logic [DATA_BITS-1:0] fifoData;
    logic                 fifoEmpty;
    logic                 pop;
    logic                 baudDone;

    uart_tx_fifo_cfg_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (in_valid),
        .data_i  (in_data),
        .pop_i   (pop),
        .data_o  (fifoData),
        .ready_o (in_ready),
        .empty_o (fifoEmpty),
        .level_o (fifo_level)
    );

    // The head word leaves the FIFO during the single LOAD cycle.
    assign pop      = (state_q == ST_LOAD);
    assign baudDone = (baudCnt_q == BAUD_LAST);

    // Frame sequencing. The baud counter is cleared in LOAD so every frame
    // starts at phase 0; bitCnt is reused for data bits and stop bits.
    always_comb begin
        state_d   = state_q;
        baudCnt_d = baudCnt_q;
        bitCnt_d  = bitCnt_q;
        shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
        parEn_d   = parEn_q;
        parBit_d  = parBit_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifoEmpty) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                shift_d   = fifoData;
                baudCnt_d = '0;
                bitCnt_d  = '0;
                state_d   = ST_START;
`ifdef UART_TX_PARITY_EN
                parEn_d   = parity_en;
                parBit_d  = (^fifoData) ^ parity_odd;
`endif
            end
            default: begin
                baudCnt_d = baudDone ? '0 : baudCnt_q + 1'b1;
                if (baudDone) begin
                    case (state_q)
                        ST_START: state_d = ST_DATA;
                        ST_DATA: begin
                            if (bitCnt_q == DATA_LAST) begin
                                bitCnt_d = '0;
`ifdef UART_TX_PARITY_EN
                                state_d  = parEn_q ? ST_PARITY : ST_STOP;
`else
                                state_d  = ST_STOP;
`endif
                            end else begin
                                bitCnt_d = bitCnt_q + 1'b1;
                                shift_d  = shift_q >> 1;
                            end
                        end
`ifdef UART_TX_PARITY_EN
                        ST_PARITY: state_d = ST_STOP;
`endif
                        ST_STOP: begin
                            if (bitCnt_q == STOP_LAST) begin
                                state_d = fifoEmpty ? ST_IDLE : ST_LOAD;
                            end else begin
                                bitCnt_d = bitCnt_q + 1'b1;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
        endcase
    end

    // The line level is computed from the next state so tx is a clean flop
    // that changes on the same edge as the state.
    always_comb begin
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parBit_d;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    // State registers; reset forces the line high immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            baudCnt_q <= '0;
            bitCnt_q  <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parEn_q   <= 1'b0;
            parBit_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baudCnt_q <= baudCnt_d;
            bitCnt_q  <= bitCnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= (state_q != ST_IDLE) || !fifoEmpty;
`ifdef UART_TX_PARITY_EN
            parEn_q   <= parEn_d;
            parBit_q  <= parBit_d;
`endif
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Self-checking bench for uart_tx_fifo_cfg.
// dut0: 8 data bits, 1 stop bit; dut1: 7 data bits, 2 stop bits; both with
// BAUD_DIV=4. A monitor per DUT samples tx at mid-bit and queues each frame
// (start bit in bit 0) with the idle-clock gap that preceded it.
module tb_uart_tx_fifo_cfg;

    localparam int BAUD = 4;
    localparam int FRAME_BITS1 = 10;
    localparam logic [15:0] BURST_EXP [6] = '{16'h202, 16'h204, 16'h206,
                                              16'h208, 16'h20A, 16'h20C};
    localparam logic [15:0] ORDER_EXP [3] = '{16'h278, 16'h386, 16'h302};

    logic       clk;
    logic       rstn;
    logic       parEn;
    logic       parOdd;
    logic       valid0, valid1;
    logic [7:0] data0;
    logic [6:0] data1;
    logic       ready0, ready1;
    logic       tx0, tx1;
    logic       busy0, busy1;
    logic [2:0] level0, level1;

    int compared = 0;
    int mismatched = 0;
    int resetCount = 0;
    int frameBits0 = 10;
    logic [15:0] frames0[$];
    logic [15:0] frames1[$];
    int gaps0[$];
    int gaps1[$];

    uart_tx_fifo_cfg #(.DATA_BITS(8), .STOP_BITS(1), .BAUD_DIV(BAUD), .FIFO_DEPTH(4)) dut0 (
        .clk        (clk),
        .rstn       (rstn),
`ifdef UART_TX_PARITY_EN
        .parity_en  (parEn),
        .parity_odd (parOdd),
`endif
        .in_valid   (valid0),
        .in_data    (data0),
        .in_ready   (ready0),
        .tx         (tx0),
        .busy       (busy0),
        .fifo_level (level0)
    );

    uart_tx_fifo_cfg #(.DATA_BITS(7), .STOP_BITS(2), .BAUD_DIV(BAUD), .FIFO_DEPTH(4)) dut1 (
        .clk        (clk),
        .rstn       (rstn),
`ifdef UART_TX_PARITY_EN
        .parity_en  (parEn),
        .parity_odd (parOdd),
`endif
        .in_valid   (valid1),
        .in_data    (data1),
        .in_ready   (ready1),
        .tx         (tx1),
        .busy       (busy1),
        .fifo_level (level1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lets the monitors discard a frame that a reset cut short.
    always @(negedge rstn) resetCount++;

    // Hard stop in case something hangs.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic txOf(input int which);
        return (which == 0) ? tx0 : tx1;
    endfunction

    // Watches one tx line: detects the start bit, samples each bit at its
    // middle and records the frame plus the idle clocks before it.
    task automatic monitorLoop(input int which);
        int idleCnt;
        int nb;
        int gap;
        int rstAtStart;
        logic [15:0] fr;
        idleCnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rstn !== 1'b1) begin
                idleCnt = 0;
            end else if (txOf(which) === 1'b0) begin
                gap = idleCnt;
                rstAtStart = resetCount;
                nb = (which == 0) ? frameBits0 : FRAME_BITS1;
                fr = '0;
                repeat (2) @(posedge clk);
                #1;
                for (int b = 0; b < nb; b++) begin
                    fr[b] = txOf(which);
                    if (b != nb - 1) begin
                        repeat (BAUD) @(posedge clk);
                        #1;
                    end
                end
                repeat (2) @(posedge clk);
                #1;
                if (resetCount == rstAtStart) begin
                    if (which == 0) begin
                        frames0.push_back(fr);
                        gaps0.push_back(gap);
                    end else begin
                        frames1.push_back(fr);
                        gaps1.push_back(gap);
                    end
                end
                idleCnt = (txOf(which) === 1'b1) ? 1 : 0;
            end else begin
                idleCnt++;
            end
        end
    endtask

    // Offers one word and holds it until the FIFO takes it.
    task automatic applyStimulus(input int which, input logic [7:0] data);
        int t;
        t = 0;
        if (which == 0) begin
            valid0 = 1'b1;
            data0  = data;
        end else begin
            valid1 = 1'b1;
            data1  = data[6:0];
        end
        while (((which == 0) ? ready0 : ready1) !== 1'b1 && t < 500) begin
            tick();
            t++;
        end
        if (t >= 500) checkOutput("push_timeout", 32'd0, 32'd1);
        tick();
        valid0 = 1'b0;
        valid1 = 1'b0;
    endtask

    task automatic waitFrames(input int which, input int n);
        int t;
        int sz;
        t = 0;
        sz = (which == 0) ? frames0.size() : frames1.size();
        while (sz < n && t < 2000) begin
            tick();
            t++;
            sz = (which == 0) ? frames0.size() : frames1.size();
        end
        checkOutput($sformatf("frame_count%0d", which), sz, n);
    endtask

    task automatic waitIdle(input int which);
        int t;
        t = 0;
        while (((which == 0) ? busy0 : busy1) !== 1'b0 && t < 500) begin
            tick();
            t++;
        end
        checkOutput($sformatf("idle%0d", which), (which == 0) ? busy0 : busy1, 1'b0);
    endtask

    initial begin
        int highCnt;
        rstn   = 1'b0;
        parEn  = 1'b0;
        parOdd = 1'b0;
        valid0 = 1'b0;
        valid1 = 1'b0;
        data0  = '0;
        data1  = '0;
        fork
            monitorLoop(0);
            monitorLoop(1);
        join_none

        // Reset values
        repeat (2) tick();
        checkOutput("rst_tx", tx0, 1'b1);
        checkOutput("rst_ready", ready0, 1'b0);
        checkOutput("rst_busy", busy0, 1'b0);
        checkOutput("rst_level", level0, 3'd0);
        checkOutput("rst_tx1", tx1, 1'b1);
        rstn = 1'b1;
        tick();
        checkOutput("ready_after_rst", ready0, 1'b1);
        repeat (3) tick();

        // 8N1 single word 0xA5: latency, bit period, busy fall
        applyStimulus(0, 8'hA5);
        checkOutput("a5_level", level0, 3'd1);
        checkOutput("a5_tx_n1", tx0, 1'b1);
        tick();
        checkOutput("a5_tx_n1b", tx0, 1'b1);
        checkOutput("a5_busy", busy0, 1'b1);
        tick();
        checkOutput("a5_fall", tx0, 1'b0);
        checkOutput("a5_level_pop", level0, 3'd0);
        repeat (3) tick();
        checkOutput("a5_start_end", tx0, 1'b0);
        tick();
        checkOutput("a5_bit0", tx0, 1'b1);
        repeat (36) tick();
        checkOutput("a5_stop_busy", busy0, 1'b1);
        checkOutput("a5_stop_tx", tx0, 1'b1);
        tick();
        checkOutput("a5_busy_drop", busy0, 1'b0);
        waitFrames(0, 1);
        checkOutput("a5_frame", (frames0.size() > 0) ? frames0[0] : 16'hFFFF, 16'h34A);
        frames0.delete();
        gaps0.delete();
        repeat (4) tick();

        // Burst into a 4-deep FIFO; level 2 -> 2 is the same-cycle push/pop
        applyStimulus(0, 8'h01);
        checkOutput("burst_lvl1", level0, 3'd1);
        applyStimulus(0, 8'h02);
        checkOutput("burst_lvl2", level0, 3'd2);
        applyStimulus(0, 8'h03);
        checkOutput("burst_pushpop_lvl", level0, 3'd2);
        applyStimulus(0, 8'h04);
        checkOutput("burst_lvl3", level0, 3'd3);
        applyStimulus(0, 8'h05);
        checkOutput("burst_lvl4", level0, 3'd4);
        checkOutput("burst_full_ready", ready0, 1'b0);
        applyStimulus(0, 8'h06);
        checkOutput("burst_retry_lvl", level0, 3'd4);
        waitFrames(0, 6);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("burst_frame%0d", i),
                        (frames0.size() > i) ? frames0[i] : 16'hFFFF, BURST_EXP[i]);
        end
        for (int i = 1; i < 6; i++) begin
            checkOutput($sformatf("burst_gap%0d", i),
                        (gaps0.size() > i) ? gaps0[i] : -1, 1);
        end
        waitIdle(0);
        frames0.delete();
        gaps0.delete();
        repeat (4) tick();

        // Order preserved across a same-cycle push and pop
        applyStimulus(0, 8'h3C);
        applyStimulus(0, 8'hC3);
        checkOutput("order_lvl2", level0, 3'd2);
        applyStimulus(0, 8'h81);
        checkOutput("order_pushpop_lvl", level0, 3'd2);
        waitFrames(0, 3);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("order_frame%0d", i),
                        (frames0.size() > i) ? frames0[i] : 16'hFFFF, ORDER_EXP[i]);
        end
        waitIdle(0);
        frames0.delete();
        gaps0.delete();

        // 7 data bits, 2 stop bits: 40-clock frame
        applyStimulus(1, 8'h7F);
        repeat (2) tick();
        checkOutput("d7_fall", tx1, 1'b0);
        repeat (3) tick();
        checkOutput("d7_start_end", tx1, 1'b0);
        repeat (37) tick();
        checkOutput("d7_stop_busy", busy1, 1'b1);
        tick();
        checkOutput("d7_busy_drop", busy1, 1'b0);
        waitFrames(1, 1);
        checkOutput("d7_frame7f", (frames1.size() > 0) ? frames1[0] : 16'hFFFF, 16'h3FE);
        applyStimulus(1, 8'h55);
        waitFrames(1, 2);
        checkOutput("d7_frame55", (frames1.size() > 1) ? frames1[1] : 16'hFFFF, 16'h3AA);
        waitIdle(1);

`ifdef UART_TX_PARITY_EN
        // Even then odd parity on 0x03 (two ones)
        frameBits0 = 11;
        parEn  = 1'b1;
        parOdd = 1'b0;
        applyStimulus(0, 8'h03);
        waitFrames(0, 1);
        checkOutput("par_even", (frames0.size() > 0) ? frames0[0] : 16'hFFFF, 16'h406);
        waitIdle(0);
        parOdd = 1'b1;
        applyStimulus(0, 8'h03);
        waitFrames(0, 2);
        checkOutput("par_odd", (frames0.size() > 1) ? frames0[1] : 16'hFFFF, 16'h606);
        waitIdle(0);
        parEn  = 1'b0;
        parOdd = 1'b0;
        frameBits0 = 10;
        frames0.delete();
        gaps0.delete();
        repeat (4) tick();
`endif

        // Reset pulse in the 4th data bit with 2 words queued
        applyStimulus(0, 8'h11);
        applyStimulus(0, 8'h22);
        applyStimulus(0, 8'h33);
        checkOutput("rstmid_lvl", level0, 3'd2);
        checkOutput("rstmid_fall", tx0, 1'b0);
        repeat (18) tick();
        checkOutput("rstmid_bit3", tx0, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("rstmid_tx", tx0, 1'b1);
        checkOutput("rstmid_level", level0, 3'd0);
        checkOutput("rstmid_busy", busy0, 1'b0);
        checkOutput("rstmid_ready", ready0, 1'b0);
        tick();
        rstn = 1'b1;
        highCnt = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (tx0 === 1'b1) highCnt++;
        end
        checkOutput("rstmid_tx_quiet", highCnt, 150);
        checkOutput("rstmid_no_frames", frames0.size(), 0);
        checkOutput("rstmid_busy_after", busy0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
